// File: rtl/sequential_left_shifter_pkg.sv
// Shared types and constants for the multi-cycle logical left shifter.
// State encodings are plain constants so legacy decode logic can reuse them.
package sequential_left_shifter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = $clog2(SHAMT_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
  typedef logic [STAGE_W-1:0] stage_t;

  // The highest stage (shift by 16) is applied first.
  localparam stage_t LAST_STAGE = stage_t'(SHAMT_W - 1);

endpackage

// File: rtl/sequential_left_shifter_if.sv
// Request/result bundle between the ALU control (master) and the shifter (slave).
interface sequential_left_shifter_if;
  import sequential_left_shifter_pkg::*;

  logic   start;
  word_t  operand;
  shamt_t shamt;
  logic   ready;
  logic   busy;
  logic   result_rdy;
  word_t  result;

  modport master (
    output start, operand, shamt,
    input  ready, busy, result_rdy, result
  );

  modport slave (
    input  start, operand, shamt,
    output ready, busy, result_rdy, result
  );

endinterface

// File: rtl/left_shift_stage.sv
// One log-stage of the left shifter: shifts by 2**stage when enabled, zero fill.
module left_shift_stage
  import sequential_left_shifter_pkg::*;
(
  input  word_t  in,
  input  stage_t stage,
  input  logic   en,
  output word_t  out
);

  assign out = en ? (in << (32'd1 << stage)) : in;

endmodule

// File: rtl/sequential_left_shifter.sv
// Multi-cycle SLL: one log-stage (16,8,4,2,1) per clock, result after 5 cycles.
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   SHIFT | applying stages LAST_STAGE..0, busy=1, start ignored
//   DONE  | result_rdy pulse, ready=1, start accepted as in IDLE
module sequential_left_shifter
  import sequential_left_shifter_pkg::*;
(
  input logic                     clock,
  input logic                     reset,
  sequential_left_shifter_if.slave bus
);

  logic [1:0] state;
  word_t      acc;
  word_t      acc_next;
  shamt_t     amt;
  stage_t     stage;
  word_t      held_result;
  logic       stage_en;

  assign stage_en = amt[stage];

  left_shift_stage u_stage (
    .in    (acc),
    .stage (stage),
    .en    (stage_en),
    .out   (acc_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      amt         <= '0;
      stage       <= '0;
      held_result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            acc   <= bus.operand;
            amt   <= bus.shamt;
            stage <= LAST_STAGE;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          // Stage 0 is the last step; the counter parks at 0 until the next start.
          if (stage == '0) begin
            held_result <= acc_next;
            state       <= DONE;
          end else begin
            stage <= stage - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = (state == IDLE) || (state == DONE);
  assign bus.busy       = (state == SHIFT);
  assign bus.result_rdy = (state == DONE);
  assign bus.result     = held_result;

endmodule

// File: tb/tb_sequential_left_shifter.sv
// Self-checking bench for sequential_left_shifter: vector table, scoreboard, corner sequences.
module tb_sequential_left_shifter;
  import sequential_left_shifter_pkg::*;

  typedef struct {
    word_t  operand;
    shamt_t shamt;
    word_t  expected;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  logic prev_rdy;
  word_t exp_q[$];

  sequential_left_shifter_if bus ();

  sequential_left_shifter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every result_rdy pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (prev_rdy) check("rdy_single_cycle", {31'd0, bus.result_rdy}, 32'd0);
    if (bus.result_rdy) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_result_rdy", 32'd1, 32'd0);
      end else begin
        check("scoreboard_result", bus.result, exp_q.pop_front());
      end
    end
    prev_rdy = bus.result_rdy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge just after the sampling edge.
  task automatic issue(input word_t op, input shamt_t sh, input word_t exp);
    check("ready_at_issue", {31'd0, bus.ready}, 32'd1);
    bus.start   = 1'b1;
    bus.operand = op;
    bus.shamt   = sh;
    exp_q.push_back(exp);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input int max_cycles);
    int n = 0;
    while (!bus.result_rdy && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check("completion_within_budget", {31'd0, bus.result_rdy}, 32'd1);
  endtask

  task automatic op_latency(input word_t op, input shamt_t sh, input word_t exp);
    issue(op, sh, exp);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      check("busy_during_shift", {31'd0, bus.busy}, 32'd1);
      check("no_early_rdy", {31'd0, bus.result_rdy}, 32'd0);
    end
    @(negedge clock);
    check("rdy_at_n_plus_5", {31'd0, bus.result_rdy}, 32'd1);
    check("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
    check("ready_in_done", {31'd0, bus.ready}, 32'd1);
    check("result_at_n_plus_5", bus.result, exp);
    @(negedge clock);
    check("rdy_dropped", {31'd0, bus.result_rdy}, 32'd0);
  endtask

  initial begin
    vec_t  vecs[8];
    word_t rop;
    shamt_t rsh;
    int    p0;

    vecs[0] = '{32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
    vecs[1] = '{32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[2] = '{32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[3] = '{32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};
    vecs[4] = '{32'h0000_FFFF, 5'd31, 32'h8000_0000};
    vecs[5] = '{32'h0000_0003, 5'd30, 32'hC000_0000};
    vecs[6] = '{32'h1234_5678, 5'd21, 32'hCF00_0000};
    vecs[7] = '{32'h0000_0001, 5'd5,  32'h0000_0020};

    checks = 0; errors = 0; pulses = 0; prev_rdy = 1'b0;
    bus.start = 1'b0; bus.operand = '0; bus.shamt = '0;
    reset = 1'b1;
    #3;
    check("reset_ready", {31'd0, bus.ready}, 32'd1);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_rdy", {31'd0, bus.result_rdy}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Latency and boundary shamts
    op_latency(32'h0000_0001, 5'd31, 32'h8000_0000);
    op_latency(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].operand, vecs[i].shamt, vecs[i].expected);
      wait_result(12);
      check("table_result", bus.result, vecs[i].expected);
      @(negedge clock);
    end

    for (int i = 0; i < 6; i++) begin
      rop = $urandom;
      rsh = shamt_t'($urandom_range(0, 31));
      issue(rop, rsh, rop << rsh);
      wait_result(12);
      @(negedge clock);
    end

    // start during SHIFT is ignored
    p0 = pulses;
    issue(32'h0000_0001, 5'd1, 32'h0000_0002);
    @(negedge clock);
    bus.start = 1'b1; bus.operand = 32'h0000_000F; bus.shamt = 5'd8;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_ignored_start", {31'd0, bus.busy}, 32'd1);
    wait_result(8);
    check("ignored_start_result", bus.result, 32'h0000_0002);
    repeat (6) @(negedge clock);
    check("one_pulse_for_ignored_start", 32'(pulses - p0), 32'd1);

    // Async reset mid-operation
    p0 = pulses;
    issue(32'h0000_00FF, 5'd4, 32'h0000_0FF0);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_rdy", {31'd0, bus.result_rdy}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("no_pulse_after_abort", 32'(pulses - p0), 32'd0);
    op_latency(32'h0000_0077, 5'd8, 32'h0000_7700);

    // Back-to-back start accepted in the DONE cycle
    p0 = pulses;
    issue(32'h0000_0005, 5'd1, 32'h0000_000A);
    wait_result(8);
    issue(32'h0000_0003, 5'd2, 32'h0000_000C);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("b2b_result_held", bus.result, 32'h0000_000A);
      check("b2b_no_rdy", {31'd0, bus.result_rdy}, 32'd0);
      @(negedge clock);
    end
    check("b2b_result_held_last", bus.result, 32'h0000_000A);
    @(negedge clock);
    check("b2b_rdy", {31'd0, bus.result_rdy}, 32'd1);
    check("b2b_result", bus.result, 32'h0000_000C);
    @(negedge clock);
    check("b2b_rdy_dropped", {31'd0, bus.result_rdy}, 32'd0);
    check("b2b_two_pulses", 32'(pulses - p0), 32'd2);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
